// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one full-adder cell with a registered carry
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, nxt;
  logic [WIDTH-2:0] p_sr;
  logic [CW-1:0]    cnt;
  logic             c, s, c_n, accept, last;
  // full-adder cell, request acceptance and next-state decode
  always_comb begin
    s       = a_sr[0] ^ b_sr[0] ^ c;
    c_n     = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    nxt     = {s, p_sr};
    accept  = start && state != SHIFT;
    last    = state == SHIFT && cnt == CW'(WIDTH - 1);
    state_n = accept ? SHIFT : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    busy    = state == SHIFT;
    done    = state == DONE;
  end
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // operand shifting, carry, partial sum and result capture on the final bit
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr <= '0;
      b_sr <= '0;
      p_sr <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (accept) begin
        a_sr <= a;
        b_sr <= b;
        c    <= cin;
        p_sr <= '0;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        c    <= c_n;
        p_sr <= nxt[WIDTH-1:1];
        cnt  <= cnt + CW'(1);
      end
      if (last) begin
        sum  <= nxt;
        cout <= c_n;
        ovf  <= c ^ c_n;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard-checked bench for serial_adder at WIDTH=8
module tb_serial_adder;
  typedef struct {logic [7:0] s; logic c; logic o;} exp_t;
  logic       clk = 0, reset = 1, start = 0, cin = 0;
  logic [7:0] a = 0, b = 0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
  int         checks = 0, errors = 0, n_acc = 0, n_done = 0;
  exp_t       q[$];
  logic [7:0] h_sum = 0;
  logic       h_c = 0, h_o = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // scoreboard: pop on each done pulse, otherwise require held outputs
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      h_sum = 0; h_c = 0; h_o = 0;
    end else if (done) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 with sum=%h, required no done", sum);
      end else begin
        e = q.pop_front();
        n_done++;
        if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
          errors++;
          $display("FAIL result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   sum, cout, ovf, e.s, e.c, e.o);
        end
        h_sum = e.s; h_c = e.c; h_o = e.o;
      end
    end else begin
      checks++;
      if (sum !== h_sum || cout !== h_c || ovf !== h_o) begin
        errors++;
        $display("FAIL hold: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                 sum, cout, ovf, h_sum, h_c, h_o);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] x, input logic [7:0] y, input logic ci);
    exp_t e;
    logic [8:0] r;
    r = {1'b0, x} + {1'b0, y} + {8'd0, ci};
    e.s = r[7:0];
    e.c = r[8];
    e.o = (x[7] == y[7]) && (r[7] != x[7]);
    q.push_back(e);
  endtask

  task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic ci);
    a = x; b = y; cin = ci; start = 1;
    push(x, y, ci);
    n_acc++;
    step();
    start = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, required done=1", n);
    end
  endtask

  task automatic count_dones(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (done) nd++;
    end
  endtask

  task automatic test_reset;
    step();
    step();
    checks++;
    if (busy !== 0 || done !== 0 || sum !== 0 || cout !== 0 || ovf !== 0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy, done, sum, cout, ovf);
    end
    reset = 0;
    step();
    checks++;
    if (busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    int n = 0, nb = 0;
    issue(8'h5A, 8'h3C, 0);
    while (!done && n < 30) begin
      if (busy) nb++;
      step();
      n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required 8", n);
    end
    checks++;
    if (nb != 8) begin
      errors++;
      $display("FAIL busy_cycles: got %0d, required 8", nb);
    end
    step();
    checks++;
    if (done !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_corners;
    logic [16:0] tbl [3] = '{{8'hFF, 8'h01, 1'b0}, {8'hFF, 8'h00, 1'b1}, {8'h7F, 8'h00, 1'b1}};
    int n;
    for (int i = 0; i < 3; i++) begin
      issue(tbl[i][16:9], tbl[i][8:1], tbl[i][0]);
      wait_done(n);
      step();
    end
  endtask

  task automatic test_ignore;
    int n, nd;
    issue(8'h10, 8'h20, 0);
    step();
    step();
    a = 8'hFF; b = 8'hFF; start = 1;
    step();
    start = 0;
    wait_done(n);
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL ignore_latency: got %0d cycles, required 5", n);
    end
    count_dones(12, nd);
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL ignore_extra_done: got %0d done pulses, required 0", nd);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    for (int i = 0; i < 3; i++) begin
      push(8'h01, 8'h01, 0);
      n_acc++;
    end
    a = 8'h01; b = 8'h01; cin = 0; start = 1;
    step();
    wait_done(n);
    for (int k = 1; k < 3; k++) begin
      step();
      wait_done(n);
      checks++;
      if (n + 1 != 9) begin
        errors++;
        $display("FAIL b2b_interval: got %0d cycles, required 9", n + 1);
      end
    end
    start = 0;
    step();
    checks++;
    if (done !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL b2b_stop: got done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_abort;
    int n, nd;
    issue(8'hAA, 8'h55, 0);
    step();
    step();
    step();
    reset = 1;
    q.delete();
    n_acc--;
    step();
    reset = 0;
    checks++;
    if (busy !== 0 || done !== 0 || sum !== 0 || cout !== 0) begin
      errors++;
      $display("FAIL abort: got busy=%b done=%b sum=%h cout=%b, required 0 0 00 0",
               busy, done, sum, cout);
    end
    count_dones(12, nd);
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL abort_done: got %0d done pulses, required 0", nd);
    end
    issue(8'h01, 8'h02, 1);
    wait_done(n);
    step();
  endtask

  task automatic test_random;
    int n;
    for (int i = 0; i < 1000; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom));
      wait_done(n);
      repeat ($urandom_range(0, 2)) step();
    end
    step();
    checks++;
    if (n_acc != n_done || q.size() != 0) begin
      errors++;
      $display("FAIL done_count: got %0d dones (%0d pending), required %0d",
               n_done, q.size(), n_acc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
